serial_sub: RTL and testbench

Bit-serial WIDTH-bit subtractor computing a − b, LSB first, one bit per clock. Each bit is computed by the existing full_sub cell, and the cell's borrow is held in a flop between cycles. The block sits directly downstream of the operand source and wraps full_sub as its per-bit datapath stage. It trades latency for area against a ripple subtractor.

---
 rtl/serial_sub.sv | 130 +++++++++++++
 tb/tb_serial_sub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock
//
// full_sub : one-bit full subtractor cell used as the per-bit datapath stage.
//   a, b, bin  : minuend bit, subtrahend bit, borrow in
//   d, bout    : difference bit, borrow out
//
// serial_sub : wraps full_sub and holds its borrow in a flop between cycles.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset; aborts any operation in progress
//   start      : request a subtraction, sampled only in IDLE
//   a, b       : operands, captured on the accepted start edge
//   busy       : high while the WIDTH bits are being processed
//   done       : one-cycle pulse, diff and borrow_out valid
//   diff       : (a - b) mod 2^WIDTH, held until the next operation completes
//   borrow_out : borrow out of the MSB (1 iff a < b unsigned)

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_q;
    logic [CW-1:0]    count;

    logic             diff_bit;
    logic             borrow_bit;
    logic [WIDTH-1:0] res_next;

    full_sub u_full_sub (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_q),
        .d    (diff_bit),
        .bout (borrow_bit)
    );

    // New difference bit enters at the MSB; after WIDTH shifts bit 0 of the
    // result has travelled down to bit 0 of the register.
    assign res_next = WIDTH'({diff_bit, res_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        res_sr   <= '0;
                        borrow_q <= 1'b0;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res_sr   <= res_next;
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    borrow_q <= borrow_bit;
                    if (count == LAST) begin
                        // Final bit: publish the result. The counter is cleared
                        // rather than incremented so it never wraps.
                        count      <= '0;
                        diff       <= res_next;
                        borrow_out <= borrow_bit;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (WIDTH=8 and WIDTH=4 instances)

module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bo4;
    logic [3:0] diff4;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    task automatic chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted start opens a window of W busy cycles
    // followed by one done cycle, after which the result is (a-b) mod 2^W.
    int          w_of[2] = '{8, 4};
    int          m_age[2];          // 0 = idle, 1..W = busy cycle, W+1 = done cycle
    int unsigned m_pa[2], m_pb[2];
    int unsigned m_diff[2];
    int unsigned m_bo[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_age[i] = 0; m_diff[i] = 0; m_bo[i] = 0; m_pa[i] = 0; m_pb[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int unsigned st, av, bv, mask;
            st   = (i == 0) ? 32'(start8) : 32'(start4);
            av   = (i == 0) ? 32'(a8) : 32'(a4);
            bv   = (i == 0) ? 32'(b8) : 32'(b4);
            mask = (32'd1 << w_of[i]) - 1;
            if (rst) begin
                m_age[i] = 0; m_diff[i] = 0; m_bo[i] = 0;
            end else if (m_age[i] == 0) begin
                if (st != 0) begin
                    m_pa[i] = av; m_pb[i] = bv; m_age[i] = 1;
                end
            end else if (m_age[i] == w_of[i]) begin
                m_age[i]  = w_of[i] + 1;
                m_diff[i] = (m_pa[i] - m_pb[i]) & mask;
                m_bo[i]   = (m_pa[i] < m_pb[i]) ? 1 : 0;
            end else if (m_age[i] == w_of[i] + 1) begin
                m_age[i] = 0;
            end else begin
                m_age[i] = m_age[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 2; i++) begin
                int unsigned eb, ed;
                eb = (m_age[i] >= 1 && m_age[i] <= w_of[i]) ? 1 : 0;
                ed = (m_age[i] == w_of[i] + 1) ? 1 : 0;
                if (i == 0) begin
                    chk("model busy w8", busy8, eb);
                    chk("model done w8", done8, ed);
                    chk("model diff w8", diff8, m_diff[0]);
                    chk("model borrow w8", bo8, m_bo[0]);
                end else begin
                    chk("model busy w4", busy4, eb);
                    chk("model done w4", done4, ed);
                    chk("model diff w4", diff4, m_diff[1]);
                    chk("model borrow w4", bo4, m_bo[1]);
                end
            end
        end
    end

    // Called just after a negedge with the DUT idle. Returns at the negedge of
    // the done cycle; edges = posedges from driving start to seeing done.
    task automatic do_op(int i, logic [7:0] av, logic [7:0] bv, output int edges, output int bc);
        if (i == 0) begin start8 = 1'b1; a8 = av; b8 = bv; end
        else        begin start4 = 1'b1; a4 = av[3:0]; b4 = bv[3:0]; end
        edges = 0;
        bc    = 0;
        do begin
            @(negedge clk);
            edges++;
            start8 = 1'b0; start4 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            if ((i == 0) ? busy8 : busy4) bc++;
        end while (!((i == 0) ? done8 : done4) && edges < 40);
    endtask

    initial begin
        int e, bc, dones;
        logic [7:0] dsave;
        logic [7:0] ta [4];
        logic [7:0] tb [4];
        logic [7:0] td [4];
        logic       tbo [4];
        ta = '{8'h05, 8'h03, 8'h00, 8'hFF};
        tb = '{8'h03, 8'h05, 8'h01, 8'hFF};
        td = '{8'h02, 8'hFE, 8'hFF, 8'h00};
        tbo = '{1'b0, 1'b1, 1'b1, 1'b0};

        // Reset then idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        chk("reset busy", busy8, 0);
        chk("reset done", done8, 0);
        chk("reset diff", diff8, 8'h00);
        chk("reset borrow", bo8, 0);
        repeat (20) @(negedge clk);
        chk("idle diff after 20", diff8, 8'h00);
        chk("idle busy after 20", busy8, 0);

        // Basic operations with hand-computed results
        for (int k = 0; k < 4; k++) begin
            do_op(0, ta[k], tb[k], e, bc);
            chk($sformatf("basic%0d latency", k), e, 9);
            chk($sformatf("basic%0d busy cycles", k), bc, 8);
            chk($sformatf("basic%0d diff", k), diff8, td[k]);
            chk($sformatf("basic%0d borrow", k), bo8, tbo[k]);
            @(negedge clk);
        end

        // Start ignored while busy
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        dones = 0; bc = 0; dsave = 8'h00;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start8 = (c == 3);
            a8 = (c == 3) ? 8'h00 : 8'h55;
            b8 = (c == 3) ? 8'hFF : 8'hAA;
            if (busy8) bc++;
            if (done8) begin dones++; dsave = diff8; end
        end
        start8 = 1'b0;
        chk("ignore done count", dones, 1);
        chk("ignore busy cycles", bc, 8);
        chk("ignore diff", dsave, 8'h0F);
        chk("ignore borrow", bo8, 0);

        // Reset in the 4th RUN cycle
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
        repeat (4) begin @(negedge clk); start8 = 1'b0; end
        chk("pre-abort busy", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy8, 0);
        chk("abort diff", diff8, 8'h00);
        dones = 0;
        repeat (12) begin @(negedge clk); if (done8) dones++; end
        chk("abort no done", dones, 0);
        do_op(0, 8'h09, 8'h04, e, bc);
        chk("post-abort diff", diff8, 8'h05);
        chk("post-abort borrow", bo8, 0);

        // Back-to-back: start in the first IDLE cycle after done
        @(negedge clk);
        do_op(0, 8'h20, 8'h30, e, bc);
        chk("b2b first diff", diff8, 8'hF0);
        @(negedge clk);
        do_op(0, 8'h77, 8'h11, e, bc);
        chk("b2b done spacing", e + 1, 10);
        chk("b2b second diff", diff8, 8'h66);
        @(negedge clk);

        // Exhaustive on the 4-bit instance
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(1, 8'(x), 8'(y), e, bc);
                chk("exh w4 diff", diff4, (x - y) & 15);
                chk("exh w4 borrow", bo4, (x < y) ? 1 : 0);
                @(negedge clk);
            end
        end

        // Random start/operand/reset traffic on the 8-bit instance
        for (int c = 0; c < 600; c++) begin
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0; start8 = 1'b0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
